// File: rtl/lut_cfg_pkg.sv
// rtl/lut_cfg_pkg.sv - shared types and sizes for the LUT6 configuration writer
package lut_cfg_pkg;

  localparam int LUT_BITS  = 64;
  localparam int ADDR_BITS = 6;
  localparam int CNT_BITS  = 7;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/lut6_read.sv
// rtl/lut6_read.sv - 64:1 read mux selecting one truth-table bit by address
module lut6_read
  import lut_cfg_pkg::*;
(
  input  logic [LUT_BITS-1:0]  lut_table,
  input  logic [ADDR_BITS-1:0] index,
  output logic                 bit_out
);

  // Pure combinational select; a partially loaded table is visible as-is.
  always_comb begin
    bit_out = lut_table[index];
  end

endmodule

// File: rtl/lut6_cfg_writer.sv
// rtl/lut6_cfg_writer.sv - LUT6 whose truth table is reloaded serially, MSB first
module lut6_cfg_writer
  import lut_cfg_pkg::*;
#(
  parameter logic [63:0] INIT = 64'h0000000000000000
) (
  input  logic        C,
  input  logic        R,
  input  logic        CE,
  input  logic        CFG_VALID,
  input  logic [63:0] CFG_DATA,
  output logic        CFG_READY,
  output logic        DONE,
  output logic        CDO,
  input  logic        I0,
  input  logic        I1,
  input  logic        I2,
  input  logic        I3,
  input  logic        I4,
  input  logic        I5,
  output logic        O,
  output logic        LO
);

  state_t                state;
  state_t                state_nxt;
  logic [LUT_BITS-1:0]   live;
  logic [LUT_BITS-1:0]   staging;
  logic [CNT_BITS-1:0]   cnt;
  logic [CNT_BITS-1:0]   cnt_inc;
  logic                  accept;
  logic                  shift_en;
  logic [ADDR_BITS-1:0]  index;
  logic                  rd_bit;

  assign index   = {I5, I4, I3, I2, I1, I0};
  assign cnt_inc = cnt + 7'd1;

  // State register; reset always lands in IDLE regardless of CE or load progress.
  always_ff @(posedge C) begin
    if (R) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state and handshake outputs; R masks both the accept and the DONE pulse.
  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    shift_en  = 1'b0;
    CFG_READY = 1'b0;
    DONE      = 1'b0;
    case (state)
      ST_IDLE: begin
        CFG_READY = !R;
        if (CFG_VALID && !R) begin
          accept    = 1'b1;
          state_nxt = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        if (CE) begin
          shift_en = 1'b1;
          if (cnt_inc == CNT_BITS'(LUT_BITS)) begin
            state_nxt = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        DONE      = !R;
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  // Datapath: capture on accept, then move one staging bit into the live table per enabled edge.
  always_ff @(posedge C) begin
    if (R) begin
      live    <= INIT;
      staging <= '0;
      cnt     <= '0;
    end else if (accept) begin
      staging <= CFG_DATA;
      cnt     <= '0;
    end else if (shift_en) begin
      live    <= {live[LUT_BITS-2:0], staging[LUT_BITS-1]};
      staging <= {staging[LUT_BITS-2:0], 1'b0};
      cnt     <= cnt_inc;
    end
  end

  // The old table leaves through the top bit as the new one enters at the bottom.
  assign CDO = live[LUT_BITS-1];

  lut6_read u_read (
    .lut_table (live),
    .index     (index),
    .bit_out   (rd_bit)
  );

`ifdef FAST_IQ
  // Debug override pairs, written only hierarchically; reset R leaves them alone.
  logic o_ovr_flag  = 1'b0;
  logic o_ovr_val   = 1'b0;
  logic lo_ovr_flag = 1'b0;
  logic lo_ovr_val  = 1'b0;

  assign O  = o_ovr_flag  ? o_ovr_val  : rd_bit;
  assign LO = lo_ovr_flag ? lo_ovr_val : rd_bit;
`else
  assign O  = rd_bit;
  assign LO = rd_bit;
`endif

endmodule

// File: doc/lut6_cfg_writer.md
LUT6_CFG_WRITER -- requirements
Module: lut6_cfg_writer

Interface
REQ-001 SHALL have parameter INIT, [63:0], default 64'h0000000000000000: truth table loaded by reset.
REQ-002 SHALL have port C, input, 1: sole clock; all state updates on rising edge.
REQ-003 SHALL have port R, input, 1: reset, synchronous, active-high.
REQ-004 SHALL have port CE, input, 1: shift enable; shifting pauses while low.
REQ-005 SHALL have port CFG_VALID, input, 1: new truth table offered.
REQ-006 SHALL have port CFG_DATA, input, 64: truth table offered, bit k = output for index k.
REQ-007 SHALL have port CFG_READY, output, 1: writer can accept a table.
REQ-008 SHALL have port DONE, output, 1: one-cycle pulse when a load completes.
REQ-009 SHALL have port CDO, output, 1: bit 63 of the live table (cascade out).
REQ-010 SHALL have ports I0..I5, input, 1 each: LUT address, index = {I5,I4,I3,I2,I1,I0}.
REQ-011 SHALL have ports O and LO, output, 1 each: both equal live_table[index].

Function
REQ-012 SHALL hold a 64-bit live table, a 64-bit staging buffer, a 7-bit shift counter and a state in {IDLE, SHIFT, DONE}.
REQ-013 SHALL drive O/LO combinationally from the live table every cycle, including mid-load (partial table visible).
REQ-014 SHALL assert CFG_READY only in IDLE and never while R is high.
REQ-015 SHALL accept on a rising edge with CFG_VALID && CFG_READY: capture CFG_DATA into staging, clear counter, enter SHIFT.
REQ-016 SHALL not accept or capture CFG_DATA while CFG_READY is low; CFG_VALID then has no effect.
REQ-017 In SHIFT with CE high, each edge SHALL do live <= {live[62:0], staging[63]}, staging <= staging << 1, counter += 1 (MSB first).
REQ-018 In SHIFT with CE low, live table, staging and counter SHALL hold.
REQ-019 The edge on which counter reaches 64 SHALL move to DONE; live table then equals captured CFG_DATA exactly.
REQ-020 DONE SHALL be high for exactly the one cycle in state DONE, then the state SHALL return to IDLE unconditionally.
REQ-021 With CE held high, latency from accept edge to DONE high SHALL be 64 cycles; CFG_READY high again 65 cycles after accept.
REQ-022 A CFG_VALID held high through DONE SHALL be accepted on the first IDLE edge, not earlier.
REQ-023 CDO SHALL equal live[63] combinationally, so the old table streams out MSB first during a load.
REQ-024 When build define FAST_IQ is set, O and LO SHALL each have a public read-write override flag/value pair (flag high selects value); the pairs reset to 0 at elaboration and are never written by R.

Reset
REQ-025 R high on an edge SHALL set live table = INIT, staging = 0, counter = 0, state = IDLE, regardless of state or CE.
REQ-026 During and after reset: CFG_READY = 0 while R is high; DONE = 0; O/LO = INIT[index]; CDO = INIT[63].
REQ-027 Reset mid-SHIFT SHALL abandon the load with no DONE pulse; the partially shifted table SHALL be replaced by INIT.
REQ-028 R SHALL take priority over a simultaneous CFG_VALID accept.

Structure
REQ-029 Package lut_cfg_pkg SHALL hold the state enum, LUT_BITS = 64, ADDR_BITS = 6 and CNT_BITS = 7.
REQ-030 The 64:1 read mux SHALL be sub-module lut6_read (table, index -> bit), instantiated once and feeding both O and LO.
REQ-031 Design SHALL be single clock domain with no latches; target 120-400 RTL lines.

Verification
REQ-032 Reset with INIT=64'h8000000000000001; idx 0 -> O=1; idx 63 -> O=1; idx 5 -> O=0; CFG_READY=0 during R; CDO=1.
REQ-033 Load 64'hFFFF0000FFFF0000 with CE=1 -> DONE exactly 64 cycles after accept; idx 16 -> O=1; idx 0 -> O=0; CFG_READY=1 at accept+65.
REQ-034 Load 64'hAAAA_AAAA_AAAA_AAAA with CE low for 10 cycles mid-shift -> DONE at accept+74; counter frozen during gap.
REQ-035 Assert R at shift 30 of a load of 64'h0123456789ABCDEF -> no DONE; table = INIT; new load accepted after R drops.
REQ-036 CFG_VALID held high across back-to-back loads A=64'h1, B=64'h2 -> B accepted at first IDLE edge after DONE of A; final idx 1 -> O=1.
REQ-037 CDO trace during a load over INIT=64'hF0F0F0F0F0F0F0F0 -> bits of INIT appear MSB first, one per enabled edge.
